wb_load_align: RTL and testbench

- Writeback stage that sits directly upstream of the register file and drives its write port (WE, Rw, Din).
- Accepts retiring instructions from the MEM stage over a valid/ready handshake.
- ALU and other non-load results go straight through a registered write port.
- Loads wait for the data-memory response. The byte, half or word is then extracted and sign- or zero-extended to XLEN before the write.

---
 rtl/wb_load_align.sv | 130 +++++++++++++
 tb/tb_wb_load_align.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_load_align.sv
// wb_load_align: writeback stage driving the register file write port.
// Non-load results pass through a registered write port. Loads wait for the
// data-memory response, then the byte/half/word/double is extracted
// (little-endian) and sign- or zero-extended before the write.
//
// Ports:
//   CLK, RST_N          clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready   handshake from the MEM stage
//   in_rd, in_wen       destination register and write intent
//   in_is_load          result comes from memory instead of in_result
//   in_funct3           load type (LB/LH/LW/LD/LBU/LHU/LWU, 111 = LD)
//   in_addr_lo          effective address bits [2:0]
//   in_result           ALU result for non-loads
//   mem_rvalid/rdata    memory response (one-cycle pulse, aligned 8-byte word)
//   WE, Rw, Din         registered register file write port
//   busy                a load is outstanding
module wb_load_align #(
    parameter int unsigned XLEN = 64,
    parameter int unsigned NREG = 32
) (
    input  logic                    CLK,
    input  logic                    RST_N,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [$clog2(NREG)-1:0] in_rd,
    input  logic                    in_wen,
    input  logic                    in_is_load,
    input  logic [2:0]              in_funct3,
    input  logic [2:0]              in_addr_lo,
    input  logic [XLEN-1:0]         in_result,
    input  logic                    mem_rvalid,
    input  logic [XLEN-1:0]         mem_rdata,
    output logic                    WE,
    output logic [$clog2(NREG)-1:0] Rw,
    output logic [XLEN-1:0]         Din,
    output logic                    busy
);

    localparam int unsigned RW = $clog2(NREG);

    typedef enum logic {
        IDLE,
        WAIT_MEM
    } state_t;

    state_t          r_state;
    logic [RW-1:0]   r_rd;
    logic            r_wen;
    logic [2:0]      r_funct3;
    logic [2:0]      r_addr_lo;
    logic            r_we;
    logic [RW-1:0]   r_rw;
    logic [XLEN-1:0] r_din;

    logic            w_xfer;
    logic [7:0]      w_byte;
    logic [15:0]     w_half;
    logic [31:0]     w_word;
    logic [XLEN-1:0] w_load;

    assign in_ready = (r_state == IDLE);
    assign busy     = (r_state == WAIT_MEM);
    assign w_xfer   = in_valid & in_ready;

    assign WE  = r_we;
    assign Rw  = r_rw;
    assign Din = r_din;

    // Low address bits are truncated to the natural alignment of the access.
    always_comb begin
        w_byte = mem_rdata[{r_addr_lo, 3'b000} +: 8];
        w_half = mem_rdata[{r_addr_lo[2:1], 4'b0000} +: 16];
        w_word = mem_rdata[{r_addr_lo[2], 5'b00000} +: 32];
        w_load = mem_rdata;
        case (r_funct3)
            3'b000:  w_load = {{(XLEN-8){w_byte[7]}}, w_byte};
            3'b001:  w_load = {{(XLEN-16){w_half[15]}}, w_half};
            3'b010:  w_load = {{(XLEN-32){w_word[31]}}, w_word};
            3'b100:  w_load = {{(XLEN-8){1'b0}}, w_byte};
            3'b101:  w_load = {{(XLEN-16){1'b0}}, w_half};
            3'b110:  w_load = {{(XLEN-32){1'b0}}, w_word};
            default: w_load = mem_rdata;
        endcase
    end

    // Rw/Din only change on a qualifying write so they hold while WE=0.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state   <= IDLE;
            r_rd      <= '0;
            r_wen     <= 1'b0;
            r_funct3  <= 3'b000;
            r_addr_lo <= 3'b000;
            r_we      <= 1'b0;
            r_rw      <= '0;
            r_din     <= '0;
        end else begin
            r_we <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_xfer) begin
                        if (in_is_load) begin
                            r_rd      <= in_rd;
                            r_wen     <= in_wen;
                            r_funct3  <= in_funct3;
                            r_addr_lo <= in_addr_lo;
                            r_state   <= WAIT_MEM;
                        end else if (in_wen && (in_rd != '0)) begin
                            r_we  <= 1'b1;
                            r_rw  <= in_rd;
                            r_din <= in_result;
                        end
                    end
                end
                WAIT_MEM: begin
                    if (mem_rvalid) begin
                        if (r_wen && (r_rd != '0)) begin
                            r_we  <= 1'b1;
                            r_rw  <= r_rd;
                            r_din <= w_load;
                        end
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_load_align.sv
module tb_wb_load_align;

    localparam int unsigned XLEN = 64;
    localparam int unsigned NREG = 32;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_rd;
    logic        in_wen;
    logic        in_is_load;
    logic [2:0]  in_funct3;
    logic [2:0]  in_addr_lo;
    logic [63:0] in_result;
    logic        mem_rvalid;
    logic [63:0] mem_rdata;
    logic        WE;
    logic [4:0]  Rw;
    logic [63:0] Din;
    logic        busy;

    int checks = 0;
    int errors = 0;

    wb_load_align #(.XLEN(XLEN), .NREG(NREG)) dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_rd      (in_rd),
        .in_wen     (in_wen),
        .in_is_load (in_is_load),
        .in_funct3  (in_funct3),
        .in_addr_lo (in_addr_lo),
        .in_result  (in_result),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .WE         (WE),
        .Rw         (Rw),
        .Din        (Din),
        .busy       (busy)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [2:0]  f3;
        logic [2:0]  addr;
        logic [63:0] exp;
    } vec_t;

    vec_t vecs[12];

    localparam logic [63:0] RDATA = 64'h8877_6655_4433_2211;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Reference: size from funct3, align the offset down, shift, mask, extend.
    function automatic logic [63:0] model_load(input logic [2:0] f3, input logic [2:0] addr,
                                               input logic [63:0] data);
        int          size;
        int          off;
        logic [63:0] v;
        logic [63:0] mask;
        size = (f3 == 3'b111) ? 8 : (1 << f3[1:0]);
        off  = int'(addr) - (int'(addr) % size);
        v    = data >> (8 * off);
        if (size < 8) begin
            mask = (64'd1 << (8 * size)) - 64'd1;
            v    = v & mask;
            if (!f3[2] && v[8 * size - 1]) v = v | ~mask;
        end
        return v;
    endfunction

    task automatic idle_inputs();
        in_valid   = 1'b0;
        in_is_load = 1'b0;
        in_wen     = 1'b0;
        in_rd      = '0;
        in_funct3  = '0;
        in_addr_lo = '0;
        in_result  = '0;
        mem_rvalid = 1'b0;
    endtask

    // Inputs driven and outputs sampled at negedge.
    task automatic do_alu(input logic [4:0] rd, input logic wen, input logic [63:0] res);
        logic exp_we;
        exp_we = wen && (rd != 0);
        check("alu_ready", in_ready, 1);
        in_valid = 1; in_is_load = 0; in_rd = rd; in_wen = wen; in_result = res;
        @(negedge CLK);
        idle_inputs();
        check("alu_we", WE, exp_we);
        if (exp_we) begin
            check("alu_rw", Rw, rd);
            check("alu_din", Din, res);
        end
        @(negedge CLK);
        check("alu_we_pulse", WE, 0);
    endtask

    task automatic do_load(input logic [4:0] rd, input logic wen, input logic [2:0] f3,
                           input logic [2:0] addr, input logic [63:0] data, input int delay,
                           input logic [63:0] exp_din);
        logic exp_we;
        exp_we = wen && (rd != 0);
        check("ld_ready", in_ready, 1);
        in_valid = 1; in_is_load = 1; in_rd = rd; in_wen = wen;
        in_funct3 = f3; in_addr_lo = addr;
        @(negedge CLK);
        idle_inputs();
        check("ld_busy", busy, 1);
        check("ld_stall", in_ready, 0);
        for (int i = 0; i < delay; i++) begin
            @(negedge CLK);
            check("ld_wait_busy", busy, 1);
            check("ld_wait_we", WE, 0);
        end
        mem_rvalid = 1; mem_rdata = data;
        @(negedge CLK);
        mem_rvalid = 0; mem_rdata = $urandom();
        check("ld_we", WE, exp_we);
        if (exp_we) begin
            check("ld_rw", Rw, rd);
            check("ld_din", Din, exp_din);
        end
        check("ld_idle_ready", in_ready, 1);
        check("ld_idle_busy", busy, 0);
        @(negedge CLK);
        check("ld_we_pulse", WE, 0);
    endtask

    initial begin
        vecs[0]  = '{3'b000, 3'd7, 64'hFFFF_FFFF_FFFF_FF88};
        vecs[1]  = '{3'b100, 3'd7, 64'h0000_0000_0000_0088};
        vecs[2]  = '{3'b001, 3'd2, 64'h0000_0000_0000_4433};
        vecs[3]  = '{3'b010, 3'd4, 64'hFFFF_FFFF_8877_6655};
        vecs[4]  = '{3'b110, 3'd4, 64'h0000_0000_8877_6655};
        vecs[5]  = '{3'b011, 3'd0, RDATA};
        vecs[6]  = '{3'b111, 3'd5, RDATA};
        vecs[7]  = '{3'b001, 3'd3, 64'h0000_0000_0000_4433};
        vecs[8]  = '{3'b001, 3'd6, 64'hFFFF_FFFF_FFFF_8877};
        vecs[9]  = '{3'b101, 3'd7, 64'h0000_0000_0000_8877};
        vecs[10] = '{3'b000, 3'd0, 64'h0000_0000_0000_0011};
        vecs[11] = '{3'b010, 3'd1, 64'h0000_0000_4433_2211};

        idle_inputs();
        mem_rdata = '0;
        RST_N = 0;
        repeat (2) @(negedge CLK);
        check("rst_we", WE, 0);
        check("rst_rw", Rw, 0);
        check("rst_din", Din, 0);
        check("rst_busy", busy, 0);
        check("rst_ready", in_ready, 1);
        RST_N = 1;
        @(negedge CLK);

        // Back-to-back non-load writes.
        in_valid = 1; in_is_load = 0; in_wen = 1; in_rd = 5; in_result = 64'h1234;
        @(negedge CLK);
        check("b2b_we0", WE, 1);
        check("b2b_rw0", Rw, 5);
        check("b2b_din0", Din, 64'h1234);
        check("b2b_ready", in_ready, 1);
        in_rd = 6; in_result = '1;
        @(negedge CLK);
        idle_inputs();
        check("b2b_we1", WE, 1);
        check("b2b_rw1", Rw, 6);
        check("b2b_din1", Din, '1);
        @(negedge CLK);
        check("b2b_we_low", WE, 0);
        check("b2b_rw_hold", Rw, 6);
        check("b2b_din_hold", Din, '1);

        // Table-driven extraction.
        for (int i = 0; i < 12; i++) begin
            do_load(5'(i + 1), 1, vecs[i].f3, vecs[i].addr, RDATA, i % 3, vecs[i].exp);
        end

        // Stall with a held instruction, response 3 cycles later.
        in_valid = 1; in_is_load = 1; in_wen = 1; in_rd = 12; in_funct3 = 3'b011;
        @(negedge CLK);
        in_is_load = 0; in_rd = 9; in_result = 64'hABCD;
        for (int i = 0; i < 3; i++) begin
            check("stall_ready", in_ready, 0);
            check("stall_busy", busy, 1);
            check("stall_we", WE, 0);
            if (i < 2) @(negedge CLK);
        end
        mem_rvalid = 1; mem_rdata = 64'h0123_4567_89AB_CDEF;
        @(negedge CLK);
        mem_rvalid = 0;
        check("stall_ld_we", WE, 1);
        check("stall_ld_rw", Rw, 12);
        check("stall_ld_din", Din, 64'h0123_4567_89AB_CDEF);
        check("stall_ready_back", in_ready, 1);
        @(negedge CLK);
        idle_inputs();
        check("stall_held_we", WE, 1);
        check("stall_held_rw", Rw, 9);
        check("stall_held_din", Din, 64'hABCD);
        @(negedge CLK);

        // x0 destinations.
        do_alu(0, 1, 64'h55);
        do_load(0, 1, 3'b011, 0, 64'h77, 2, 64'h77);

        // Spurious response in IDLE.
        mem_rvalid = 1; mem_rdata = 64'h99;
        @(negedge CLK);
        mem_rvalid = 0;
        check("spur_we", WE, 0);
        check("spur_busy", busy, 0);

        // Response coincident with the load transfer is ignored.
        in_valid = 1; in_is_load = 1; in_wen = 1; in_rd = 20; in_funct3 = 3'b100; in_addr_lo = 1;
        mem_rvalid = 1; mem_rdata = 64'hAAAA;
        @(negedge CLK);
        idle_inputs();
        check("same_we", WE, 0);
        check("same_busy", busy, 1);
        @(negedge CLK);
        check("same_busy2", busy, 1);
        mem_rvalid = 1; mem_rdata = 64'h3300;
        @(negedge CLK);
        mem_rvalid = 0;
        check("same_late_we", WE, 1);
        check("same_late_din", Din, 64'h33);

        // Reset mid-load.
        @(negedge CLK);
        in_valid = 1; in_is_load = 1; in_wen = 1; in_rd = 7; in_funct3 = 3'b011;
        @(negedge CLK);
        idle_inputs();
        check("mid_busy", busy, 1);
        RST_N = 0;
        #1;
        check("mid_rst_we", WE, 0);
        check("mid_rst_rw", Rw, 0);
        check("mid_rst_din", Din, 0);
        check("mid_rst_busy", busy, 0);
        @(negedge CLK);
        RST_N = 1;
        mem_rvalid = 1; mem_rdata = 64'hDEAD;
        @(negedge CLK);
        mem_rvalid = 0;
        check("post_rst_we", WE, 0);
        check("post_rst_ready", in_ready, 1);
        check("post_rst_din", Din, 0);

        // Randomized mix against the reference model.
        for (int n = 0; n < 200; n++) begin
            logic [4:0]  rd;
            logic        wen;
            logic [2:0]  f3;
            logic [2:0]  addr;
            logic [63:0] data;
            rd   = 5'($urandom_range(0, 31));
            wen  = ($urandom_range(0, 7) != 0);
            f3   = 3'($urandom_range(0, 7));
            addr = 3'($urandom_range(0, 7));
            data = {$urandom(), $urandom()};
            if ($urandom_range(0, 2) == 0) begin
                do_alu(rd, wen, data);
            end else begin
                do_load(rd, wen, f3, addr, data, int'($urandom_range(0, 3)),
                        model_load(f3, addr, data));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
